commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU core's commit interface, one entry per retired instruction.
- Captures each commit record and keeps performance counters: retired count, control-transfer count, prediction-miss count.
- Buffers records in a FIFO and drains them to a trace/difftest consumer over a valid/ready handshake.
- Overflow drops records but never stalls the core; drops are counted.

Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥2)
- PTR_W, 3, log2(DEPTH)
- CNT_W, 32, width of every performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- commit  in  1  core retires one instruction this cycle
- commit_pc  in  32  PC of the retired instruction
- instr  in  32  retired instruction word
- commit_pre_pc  in  32  actual next PC after the instruction
- commit_pred_pc  in  32  next PC predicted at fetch
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts head record
- trace_pc  out  32  head record PC
- trace_instr  out  32  head record instruction
- trace_next_pc  out  32  head record actual next PC
- trace_mispred  out  1  head record was mispredicted
- retired_cnt  out  CNT_W  instructions retired
- ctrl_cnt  out  CNT_W  retired branch/JAL/JALR instructions
- mispred_cnt  out  CNT_W  retired with commit_pre_pc != commit_pred_pc
- drop_cnt  out  CNT_W  records lost to overflow
- overflow  out  1  sticky; set on first drop
- halted  out  1  ebreak retired (feature only; tied 0 otherwise)

Behaviour:
- Reset (rst==0 at posedge): FIFO empty; all counters 0; overflow=0; halted=0; trace_valid=0; trace_* data=0.
- Control-transfer test: instr[6:0] ∈ {7'b1100011, 7'b1101111, 7'b1100111}.
- Mispredict test: commit_pre_pc != commit_pred_pc, full 32-bit compare.
- Counters update on every cycle with commit=1, regardless of FIFO state:
  - retired_cnt += 1
  - ctrl_cnt += 1 if control transfer
  - mispred_cnt += 1 if mispredicted
- Counters wrap modulo 2^CNT_W silently.
- FIFO storage: registered circular buffer, wr_ptr/rd_ptr PTR_W bits plus a count register 0..DEPTH.
- push = commit && (count<DEPTH || pop). pop = trace_valid && trace_ready.
- Latency: a record pushed at edge N is visible on trace_* after edge N (registered). There is no same-cycle bypass.
- trace_valid = (count!=0). trace_* shows mem[rd_ptr] and holds stable while trace_valid && !trace_ready.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Allowed when full (count==DEPTH); no drop in that case.
- Full and commit with no pop: record discarded, drop_cnt += 1, overflow set. overflow clears only on reset.
- Empty and pop: impossible (trace_valid=0). trace_ready is ignored when empty.
- Pointers wrap DEPTH-1 -> 0.
- Reset mid-drain: state discarded immediately at the edge; no partial record is emitted.

Optional Feature:
- Macro: COMMIT_TRACE_HALT_EN.
- When defined:
  - A retired instr==32'h0010_0073 (ebreak) sets halted=1 (sticky until reset).
  - The ebreak record itself is pushed and counted.
  - Every later commit is ignored: no push, no counter change, no drop.
- When undefined: halted is tied 0 and there is no ebreak decode.

Decomposition:
- Shared package/include `define.v` holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - EBREAK_INSTR
  - record width constant TRACE_REC_W = 97 ({pc, instr, next_pc, mispred})
- One sub-module, trace_fifo: a generic DEPTH×TRACE_REC_W registered FIFO with push/pop/full/empty/count.
- Counters and halt logic stay in the top module.

Test Plan:
- Reset then 3 commits (pc 0x0,0x4,0x8; pre_pc==pred_pc; instr 0x00000013), trace_ready=1 -> 3 records in order, each appearing one cycle after its commit; retired_cnt=3, ctrl_cnt=0, mispred_cnt=0.
- Commit beq (instr 0x00000063) with pre_pc=0x100, pred_pc=0x4 -> trace_mispred=1, trace_next_pc=0x100; ctrl_cnt=1, mispred_cnt=1.
- trace_ready=0, 10 commits with DEPTH=8 -> count saturates at 8, drop_cnt=2, overflow=1; then drain -> exactly the first 8 PCs emerge in order.
- FIFO full, commit with trace_ready=1 in the same cycle -> no drop, count stays 8, head advances by one record.
- Hold trace_ready=0 for 5 cycles with a record pending -> trace_* stable and trace_valid=1 throughout; rst=0 for one cycle mid-hold -> next cycle trace_valid=0 and all counters 0.
- With COMMIT_TRACE_HALT_EN: commit 0x00100073 then 2 more commits -> halted=1, retired_cnt=1, exactly one record emitted.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// Shared constants and record layout for the commit trace buffer.
package commit_trace_buffer_pkg;

  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [6:0]  OP_JAL       = 7'b1101111;
  localparam logic [6:0]  OP_JALR      = 7'b1100111;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  localparam int unsigned TRACE_REC_W = 97;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        mispred;
  } trace_rec_t;

  function automatic logic is_ctrl(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Generic registered circular FIFO; push while full is honoured only alongside a pop.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned W     = 97
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture with performance counters and a drop-on-overflow FIFO.
// Optional ebreak halt enabled by defining COMMIT_TRACE_HALT_EN.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      instr,
  input  logic [31:0]      commit_pre_pc,
  input  logic [31:0]      commit_pred_pc,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_instr,
  output logic [31:0]      trace_next_pc,
  output logic             trace_mispred,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow,
  output logic             halted
);

  logic             accept;
  logic             halted_q;
  logic             mispred;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_count;
  trace_rec_t       wr_rec;
  trace_rec_t       head_rec;

`ifdef COMMIT_TRACE_HALT_EN
  // The ebreak itself is accepted; only commits after it are ignored.
  always_ff @(posedge clk) begin
    if (!rst)                                    halted_q <= 1'b0;
    else if (accept && (instr == EBREAK_INSTR))  halted_q <= 1'b1;
  end
  assign accept = commit && !halted_q;
`else
  assign halted_q = 1'b0;
  assign accept   = commit;
`endif

  assign halted  = halted_q;
  assign mispred = (commit_pre_pc != commit_pred_pc);

  assign trace_valid = (fifo_count != '0);
  assign pop         = !fifo_empty && trace_ready;
  assign push        = accept && (!fifo_full || pop);
  assign drop        = accept && fifo_full && !pop;

  always_comb begin
    wr_rec         = '0;
    wr_rec.pc      = commit_pc;
    wr_rec.instr   = instr;
    wr_rec.next_pc = commit_pre_pc;
    wr_rec.mispred = mispred;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (TRACE_REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign trace_pc      = head_rec.pc;
  assign trace_instr   = head_rec.instr;
  assign trace_next_pc = head_rec.next_pc;
  assign trace_mispred = head_rec.mispred;

  // Counters track every accepted commit, independent of FIFO occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_cnt <= '0;
      ctrl_cnt    <= '0;
      mispred_cnt <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept) begin
        retired_cnt <= retired_cnt + 1'b1;
        if (is_ctrl(instr[6:0])) ctrl_cnt    <= ctrl_cnt + 1'b1;
        if (mispred)             mispred_cnt <= mispred_cnt + 1'b1;
      end
      if (drop) begin
        drop_cnt <= drop_cnt + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer; honours COMMIT_TRACE_HALT_EN when defined.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        mispred;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             commit;
  logic [31:0]      commit_pc;
  logic [31:0]      instr;
  logic [31:0]      commit_pre_pc;
  logic [31:0]      commit_pred_pc;
  logic             trace_valid;
  logic             trace_ready;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;
  logic [31:0]      trace_next_pc;
  logic             trace_mispred;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] ctrl_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;
  logic             halted;

  commit_trace_buffer #(
    .DEPTH (DEPTH),
    .PTR_W (3),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .commit         (commit),
    .commit_pc      (commit_pc),
    .instr          (instr),
    .commit_pre_pc  (commit_pre_pc),
    .commit_pred_pc (commit_pred_pc),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_instr    (trace_instr),
    .trace_next_pc  (trace_next_pc),
    .trace_mispred  (trace_mispred),
    .retired_cnt    (retired_cnt),
    .ctrl_cnt       (ctrl_cnt),
    .mispred_cnt    (mispred_cnt),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model, stepped on the falling edge from the inputs the next rising edge will see.
  rec_t        q[$];
  logic [31:0] exp_retired = '0;
  logic [31:0] exp_ctrl    = '0;
  logic [31:0] exp_mispred = '0;
  logic [31:0] exp_drop    = '0;
  logic        exp_ovf     = 1'b0;
  logic        exp_halted  = 1'b0;
  int unsigned pops        = 0;

  always @(negedge clk) begin
    rec_t r;
    logic pop_now;
    logic [6:0] op;
    if (!rst) begin
      q.delete();
      exp_retired = '0;
      exp_ctrl    = '0;
      exp_mispred = '0;
      exp_drop    = '0;
      exp_ovf     = 1'b0;
      exp_halted  = 1'b0;
    end else begin
      check("trace_valid", trace_valid, q.size() != 0);
      pop_now = (q.size() != 0) && trace_ready;
      if (pop_now) begin
        r = q.pop_front();
        check("head_pc",      trace_pc,      r.pc);
        check("head_instr",   trace_instr,   r.instr);
        check("head_next_pc", trace_next_pc, r.next_pc);
        check("head_mispred", trace_mispred, r.mispred);
        pops++;
      end
      if (commit && !exp_halted) begin
        op = instr[6:0];
        exp_retired++;
        if (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111) exp_ctrl++;
        if (commit_pre_pc != commit_pred_pc) exp_mispred++;
        if (q.size() < DEPTH || pop_now) begin
          r.pc      = commit_pc;
          r.instr   = instr;
          r.next_pc = commit_pre_pc;
          r.mispred = (commit_pre_pc != commit_pred_pc);
          q.push_back(r);
        end else begin
          exp_drop++;
          exp_ovf = 1'b1;
        end
`ifdef COMMIT_TRACE_HALT_EN
        if (instr == 32'h0010_0073) exp_halted = 1'b1;
`endif
      end
    end
  end

  task automatic drive(input logic c, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] pre, input logic [31:0] pred, input logic rdy);
    commit         = c;
    commit_pc      = pc;
    instr          = ins;
    commit_pre_pc  = pre;
    commit_pred_pc = pred;
    trace_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, rdy);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_retired"}, retired_cnt, exp_retired);
    check({tag, "_ctrl"},    ctrl_cnt,    exp_ctrl);
    check({tag, "_mispred"}, mispred_cnt, exp_mispred);
    check({tag, "_drop"},    drop_cnt,    exp_drop);
    check({tag, "_ovf"},     overflow,    exp_ovf);
    check({tag, "_halted"},  halted,      exp_halted);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] instr_tab [5];
    int unsigned pops0;
    instr_tab[0] = 32'h0000_0013;
    instr_tab[1] = 32'h0000_0063;
    instr_tab[2] = 32'h0000_006F;
    instr_tab[3] = 32'h0000_0067;
    instr_tab[4] = 32'h0020_8033;

    rst = 1'b0;
    idle(1'b0, 2);
    check("rst_valid",   trace_valid, 1'b0);
    check("rst_pc",      trace_pc,    32'h0);
    check("rst_instr",   trace_instr, 32'h0);
    check("rst_retired", retired_cnt, 32'h0);
    check("rst_drop",    drop_cnt,    32'h0);
    check("rst_ovf",     overflow,    1'b0);
    check("rst_halted",  halted,      1'b0);
    rst = 1'b1;

    // Three sequential nops, each visible right after its commit edge
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), 32'h13, 32'(4 * i + 4), 32'(4 * i + 4), 1'b1);
      check("nop_visible", trace_valid, 1'b1);
      check("nop_pc",      trace_pc,    32'(4 * i));
    end
    idle(1'b1, 2);
    check("nop_retired", retired_cnt, 32'd3);
    check("nop_ctrl",    ctrl_cnt,    32'd0);
    check("nop_mispred", mispred_cnt, 32'd0);

    // Mispredicted branch
    drive(1'b1, 32'h10, 32'h63, 32'h100, 32'h4, 1'b0);
    check("beq_mispred", trace_mispred, 1'b1);
    check("beq_next_pc", trace_next_pc, 32'h100);
    check("beq_ctrl",    ctrl_cnt,      32'd1);
    check("beq_misp",    mispred_cnt,   32'd1);
    idle(1'b1, 2);

    // Overflow: 10 commits into 8 entries with consumer stalled
    for (int unsigned i = 0; i < 10; i++)
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h13, 32'h0, 32'h0, 1'b0);
    check("ovf_drop", drop_cnt, 32'd2);
    check("ovf_flag", overflow, 1'b1);
    idle(1'b1, 10);
    check("ovf_drained", q.size(), 0);

    // Full FIFO with simultaneous push and pop
    for (int unsigned i = 0; i < 8; i++)
      drive(1'b1, 32'h300 + 32'(4 * i), 32'h13, 32'h0, 32'h0, 1'b0);
    check("full_head", trace_pc, 32'h300);
    drive(1'b1, 32'h340, 32'h13, 32'h0, 32'h0, 1'b1);
    check("full_nodrop", drop_cnt, 32'd2);
    check("full_head_adv", trace_pc, 32'h304);
    check("full_count", q.size(), DEPTH);
    idle(1'b1, 10);
    check_counters("after_full");

    // Stall hold, then reset in the middle of it
    drive(1'b1, 32'h400, 32'h13, 32'h404, 32'h404, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      idle(1'b0, 1);
      check("hold_valid", trace_valid, 1'b1);
      check("hold_pc",    trace_pc,    32'h400);
      check("hold_next",  trace_next_pc, 32'h404);
    end
    rst = 1'b0;
    idle(1'b0, 1);
    rst = 1'b1;
    check("mid_rst_valid",   trace_valid, 1'b0);
    check("mid_rst_retired", retired_cnt, 32'd0);
    check("mid_rst_ctrl",    ctrl_cnt,    32'd0);
    check("mid_rst_mispred", mispred_cnt, 32'd0);
    check("mid_rst_drop",    drop_cnt,    32'd0);
    check("mid_rst_ovf",     overflow,    1'b0);

    // Random traffic against the scoreboard
    for (int unsigned i = 0; i < 300; i++) begin
      logic [31:0] pre;
      pre = $urandom;
      drive(1'($urandom_range(0, 1)), $urandom, instr_tab[$urandom_range(0, 4)], pre,
            ($urandom_range(0, 1) != 0) ? pre : pre ^ 32'h8, ($urandom_range(0, 3) == 0));
    end
    idle(1'b1, DEPTH + 2);
    check("rand_drained", q.size(), 0);
    check_counters("rand");

`ifdef COMMIT_TRACE_HALT_EN
    rst = 1'b0;
    idle(1'b0, 1);
    rst = 1'b1;
    pops0 = pops;
    drive(1'b1, 32'h500, 32'h0010_0073, 32'h504, 32'h504, 1'b1);
    drive(1'b1, 32'h504, 32'h13, 32'h508, 32'h508, 1'b1);
    drive(1'b1, 32'h508, 32'h63, 32'h0, 32'h50c, 1'b1);
    idle(1'b1, 3);
    check("halt_flag",    halted,       1'b1);
    check("halt_retired", retired_cnt,  32'd1);
    check("halt_ctrl",    ctrl_cnt,     32'd0);
    check("halt_drop",    drop_cnt,     32'd0);
    check("halt_records", pops - pops0, 1);
`else
    pops0 = pops;
    drive(1'b1, 32'h500, 32'h0010_0073, 32'h504, 32'h504, 1'b1);
    idle(1'b1, 2);
    check("nohalt_flag",    halted,       1'b0);
    check("nohalt_records", pops - pops0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
